// File: rtl/wave_generator.sv
// Configurable sample-per-cycle waveform source: saw up/down, triangle and square,
// always clamped to the active [lo, hi] window.
//
// state   | meaning
// ST_UP   | triangle rising; dir=0
// ST_DOWN | triangle falling; dir=1
module wave_generator #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         cfg_load,
  input  logic [1:0]   mode,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] step,
  output logic [N-1:0] out,
  output logic         dir,
  output logic         wrap,
  output logic         cfg_err
);

  typedef enum logic [1:0] {
    MODE_SAW_UP   = 2'd0,
    MODE_SAW_DOWN = 2'd1,
    MODE_TRIANGLE = 2'd2,
    MODE_SQUARE   = 2'd3
  } mode_t;

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } tri_state_t;

  localparam logic [N-1:0] ONE = N'(1);

  mode_t      r_mode;
  logic [N-1:0] r_lo;
  logic [N-1:0] r_hi;
  logic [N-1:0] r_step;
  logic [N-1:0] r_out;
  logic [N-1:0] r_phase;
  logic         r_dir;
  logic         r_wrap;
  tri_state_t   r_state;

  mode_t      w_mode_nxt;
  logic [N-1:0] w_lo_nxt;
  logic [N-1:0] w_hi_nxt;
  logic [N-1:0] w_step_nxt;
  logic [N-1:0] w_out_nxt;
  logic [N-1:0] w_phase_nxt;
  logic         w_dir_nxt;
  logic         w_wrap_nxt;
  tri_state_t   w_state_nxt;

  logic         w_cfg_err;
  logic         w_load_bad;
  logic [N-1:0] w_step_eff;
  logic [N:0]   w_out_add;
  logic [N:0]   w_dn_floor;
  logic [N-1:0] w_out_inc;
  logic [N-1:0] w_out_dec;
  logic [N:0]   w_ph_add;
  logic [N-1:0] w_ph_inc;

  assign w_cfg_err  = (r_lo >= r_hi);
  assign w_load_bad = (lo >= hi);
  assign w_step_eff = (r_step == '0) ? ONE : r_step;

  // Sums are one bit wider so a step past hi saturates instead of wrapping.
  assign w_out_add  = {1'b0, r_out} + {1'b0, w_step_eff};
  assign w_out_inc  = (w_out_add > {1'b0, r_hi}) ? r_hi : w_out_add[N-1:0];
  assign w_dn_floor = {1'b0, r_lo} + {1'b0, w_step_eff};
  assign w_out_dec  = ({1'b0, r_out} < w_dn_floor) ? r_lo : (r_out - w_step_eff);
  assign w_ph_add   = {1'b0, r_phase} + {1'b0, w_step_eff};
  assign w_ph_inc   = (w_ph_add > {1'b0, r_hi}) ? r_hi : w_ph_add[N-1:0];

  always_comb begin
    w_mode_nxt  = r_mode;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_step_nxt  = r_step;
    w_out_nxt   = r_out;
    w_phase_nxt = r_phase;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    w_state_nxt = r_state;

    if (cfg_load) begin
      w_mode_nxt  = mode_t'(mode);
      w_lo_nxt    = lo;
      w_hi_nxt    = hi;
      w_step_nxt  = step;
      w_phase_nxt = lo;
      w_state_nxt = ST_UP;
      if (!w_load_bad && (mode_t'(mode) == MODE_SAW_DOWN)) begin
        w_out_nxt = hi;
        w_dir_nxt = 1'b1;
      end else begin
        w_out_nxt = lo;
        w_dir_nxt = 1'b0;
      end
    end else if (w_cfg_err) begin
      w_out_nxt = r_lo;
      w_dir_nxt = 1'b0;
    end else if (ena) begin
      unique case (r_mode)
        MODE_SAW_UP: begin
          w_dir_nxt = 1'b0;
          if (r_out == r_hi) begin
            w_out_nxt  = r_lo;
            w_wrap_nxt = 1'b1;
          end else begin
            w_out_nxt = w_out_inc;
          end
        end
        MODE_SAW_DOWN: begin
          w_dir_nxt = 1'b1;
          if (r_out == r_lo) begin
            w_out_nxt  = r_hi;
            w_wrap_nxt = 1'b1;
          end else begin
            w_out_nxt = w_out_dec;
          end
        end
        MODE_TRIANGLE: begin
          // Turn around on the sample that lands on the bound so peaks are not repeated.
          if (r_state == ST_UP) begin
            w_out_nxt = w_out_inc;
            if (w_out_inc == r_hi) begin
              w_state_nxt = ST_DOWN;
              w_dir_nxt   = 1'b1;
            end else begin
              w_dir_nxt = 1'b0;
            end
          end else begin
            w_out_nxt = w_out_dec;
            if (w_out_dec == r_lo) begin
              w_state_nxt = ST_UP;
              w_dir_nxt   = 1'b0;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_dir_nxt = 1'b1;
            end
          end
        end
        MODE_SQUARE: begin
          if (r_phase == r_hi) begin
            w_phase_nxt = r_lo;
            w_wrap_nxt  = 1'b1;
            w_dir_nxt   = ~r_dir;
            w_out_nxt   = r_dir ? r_lo : r_hi;
          end else begin
            w_phase_nxt = w_ph_inc;
            w_out_nxt   = r_dir ? r_hi : r_lo;
          end
        end
        default: begin
          w_out_nxt = r_out;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_TRIANGLE;
      r_lo   <= '0;
      r_hi   <= '1;
      r_step <= ONE;
    end else begin
      r_mode <= w_mode_nxt;
      r_lo   <= w_lo_nxt;
      r_hi   <= w_hi_nxt;
      r_step <= w_step_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out   <= '0;
      r_phase <= '0;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
      r_state <= ST_UP;
    end else begin
      r_out   <= w_out_nxt;
      r_phase <= w_phase_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
      r_state <= w_state_nxt;
    end
  end

  assign out     = r_out;
  assign dir     = r_dir;
  assign wrap    = r_wrap;
  assign cfg_err = w_cfg_err;

endmodule

// File: tb/tb_wave_generator.sv
// Scoreboard bench for wave_generator: the driver pushes expected samples from an
// index-based waveform model, a monitor pops and compares after every clock edge.
module tb_wave_generator;

  localparam int N    = 8;
  localparam int MAXV = (1 << N) - 1;

  typedef struct {
    logic [N-1:0] out;
    logic         dir;
    logic         wrap;
    logic         err;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ena = 1'b0;
  logic         cfg_load = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] lo = '0;
  logic [N-1:0] hi = '0;
  logic [N-1:0] step = '0;
  logic [N-1:0] d_out;
  logic         d_dir;
  logic         d_wrap;
  logic         d_err;

  logic         t_rst = 1'b1;
  logic         t_ena = 1'b0;
  logic         t_ld = 1'b0;
  logic [1:0]   t_mode = 2'd0;
  logic [N-1:0] t_lo = '0;
  logic [N-1:0] t_hi = '0;
  logic [N-1:0] t_step = '0;

  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;
  exp_t exp_q[$];

  // Model state: waveform position as a sample index within the period.
  int m_mode, m_lo, m_hi, m_step, m_idx;
  bit m_sq, m_wrap;

  wave_generator #(.N(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .cfg_load(cfg_load), .mode(mode),
    .lo(lo), .hi(hi), .step(step),
    .out(d_out), .dir(d_dir), .wrap(d_wrap), .cfg_err(d_err)
  );

  always #5 clk = ~clk;

  function automatic int eff_s();
    return (m_step == 0) ? 1 : m_step;
  endfunction

  // Samples needed to walk from one bound to the other.
  function automatic int span_steps();
    return (m_hi - m_lo + eff_s() - 1) / eff_s();
  endfunction

  task automatic model_step(input bit r, input bit e, input bit ld,
                            input int md, input int l, input int h, input int s);
    m_wrap = 1'b0;
    if (r) begin
      m_mode = 2; m_lo = 0; m_hi = MAXV; m_step = 1; m_idx = 0; m_sq = 1'b0;
    end else if (ld) begin
      m_mode = md; m_lo = l; m_hi = h; m_step = s; m_idx = 0; m_sq = 1'b0;
    end else if (m_lo < m_hi && e) begin
      m_idx++;
      if (m_mode == 2) begin
        if (m_idx == 2 * span_steps()) begin m_idx = 0; m_wrap = 1'b1; end
      end else if (m_idx == span_steps() + 1) begin
        m_idx  = 0;
        m_wrap = 1'b1;
        if (m_mode == 3) m_sq = ~m_sq;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t x;
    int   v, half;
    x.cyc  = 0;
    x.err  = (m_lo >= m_hi);
    x.wrap = m_wrap;
    v      = m_lo;
    x.dir  = 1'b0;
    if (!x.err) begin
      case (m_mode)
        0: begin v = m_lo + m_idx * eff_s(); if (v > m_hi) v = m_hi; end
        1: begin v = m_hi - m_idx * eff_s(); if (v < m_lo) v = m_lo; x.dir = 1'b1; end
        2: begin
          half = span_steps();
          if (m_idx < half) begin
            v = m_lo + m_idx * eff_s(); if (v > m_hi) v = m_hi;
          end else begin
            v = m_hi - (m_idx - half) * eff_s(); if (v < m_lo) v = m_lo;
            x.dir = 1'b1;
          end
        end
        default: begin v = m_sq ? m_hi : m_lo; x.dir = m_sq; end
      endcase
    end
    x.out = N'(v);
    return x;
  endfunction

  task automatic tick();
    logic rst_was;
    exp_t e;
    @(negedge clk);
    rst_was  = rst;
    rst      = t_rst;
    ena      = t_ena;
    cfg_load = t_ld;
    mode     = t_mode;
    lo       = t_lo;
    hi       = t_hi;
    step     = t_step;
    if (t_rst && !rst_was) begin
      #1;
      checks++;
      if (d_out !== '0 || d_dir !== 1'b0 || d_wrap !== 1'b0) begin
        errors++;
        $display("FAIL async_reset t=%0t got out=%0d dir=%0b wrap=%0b want out=0 dir=0 wrap=0",
                 $time, d_out, d_dir, d_wrap);
      end
    end
    model_step(t_rst, t_ena, t_ld, int'(t_mode), int'(t_lo), int'(t_hi), int'(t_step));
    e     = model_out();
    e.cyc = cyc_n++;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit e);
    t_ld = 1'b0; t_ena = e;
    repeat (n) tick();
  endtask

  task automatic load(input int md, input int l, input int h, input int s, input bit e);
    t_mode = 2'(md); t_lo = N'(l); t_hi = N'(h); t_step = N'(s);
    t_ld = 1'b1; t_ena = e;
    tick();
    t_ld = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (d_out !== e.out || d_dir !== e.dir || d_wrap !== e.wrap || d_err !== e.err) begin
          errors++;
          $display("FAIL sample cyc=%0d got out=%0d dir=%0b wrap=%0b err=%0b want out=%0d dir=%0b wrap=%0b err=%0b",
                   e.cyc, d_out, d_dir, d_wrap, d_err, e.out, e.dir, e.wrap, e.err);
        end
      end
    end
  end

  initial begin : stimulus
    int md, l, h, s, n;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (d_out !== '0 || d_dir !== 1'b0 || d_wrap !== 1'b0 || d_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial got out=%0d dir=%0b wrap=%0b err=%0b want all 0",
               d_out, d_dir, d_wrap, d_err);
    end

    // Reset held with cfg_load and ena toggling: both must be ignored.
    t_rst = 1'b1; t_mode = 2'd0; t_lo = 8'd9; t_hi = 8'd30; t_step = 8'd3;
    t_ld = 1'b1; t_ena = 1'b1;
    repeat (3) tick();
    t_rst = 1'b0; t_ld = 1'b0;

    // Default full-range triangle, beyond one 510-sample period.
    run(515, 1'b1);

    // Reload mid-triangle with ena high, then small triangle.
    run(37, 1'b1);
    load(2, 0, 7, 3, 1'b1);
    run(10, 1'b1);

    load(0, 10, 20, 4, 1'b1);
    run(10, 1'b1);

    load(1, 50, 50, 3, 1'b1);
    run(5, 1'b1);
    load(1, 0, 5, 2, 1'b0);
    run(8, 1'b1);

    // Square with step 0 and gated ena, then an asynchronous reset mid-run.
    load(3, 2, 200, 0, 1'b0);
    for (int i = 0; i < 460; i++) begin
      t_ena = ($urandom_range(0, 3) != 0);
      tick();
    end
    run(3, 1'b0);
    t_rst = 1'b1; t_ld = 1'b1; t_mode = 2'd3; t_lo = 8'd1; t_hi = 8'd9;
    run(2, 1'b1);
    t_rst = 1'b0;
    run(20, 1'b1);

    for (int k = 0; k < 30; k++) begin
      md = $urandom_range(0, 3);
      l  = $urandom_range(0, MAXV);
      case ($urandom_range(0, 9))
        0:       h = l;
        1:       h = $urandom_range(0, l);
        default: h = $urandom_range(l, MAXV);
      endcase
      case ($urandom_range(0, 5))
        0:       s = 0;
        1:       s = $urandom_range(41, MAXV);
        default: s = $urandom_range(1, 40);
      endcase
      load(md, l, h, s, 1'($urandom_range(0, 1)));
      n = $urandom_range(40, 160);
      for (int i = 0; i < n; i++) begin
        t_ena = ($urandom_range(0, 4) != 0);
        t_rst = ($urandom_range(0, 99) == 0);
        tick();
      end
      t_rst = 1'b0;
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_generator.md
WAVE_GENERATOR -- requirements
Module: wave_generator

Interface
REQ-001 SHALL have parameter N, default 8, giving the sample and config width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port ena, input, 1 bit: advance one sample per cycle when high; hold all state when low.
REQ-005 SHALL have port cfg_load, input, 1 bit: latch the configuration inputs and restart the waveform.
REQ-006 SHALL have port mode, input, 2 bits: 0 SAW_UP, 1 SAW_DOWN, 2 TRIANGLE, 3 SQUARE.
REQ-007 SHALL have ports lo and hi, input, N bits each: lower and upper output bounds.
REQ-008 SHALL have port step, input, N bits: per-sample increment.
REQ-009 SHALL have port out, output, N bits: the current sample (registered).
REQ-010 SHALL have port dir, output, 1 bit: 0 means rising or SQUARE low level; 1 means falling or SQUARE high level.
REQ-011 SHALL have port wrap, output, 1 bit: registered single-cycle period-boundary pulse.
REQ-012 SHALL have port cfg_err, output, 1 bit: the active configuration is illegal.

Function
REQ-013 SHALL drive waveform behaviour only from active config registers (mode, lo, hi, step), which change only on cfg_load or reset.
REQ-014 SHALL give cfg_load priority over ena: latch the inputs regardless of ena, set wrap=0, and restart with out=hi, dir=1 for SAW_DOWN, otherwise out=lo, dir=0; internal phase counter=lo.
REQ-015 SHALL use an effective step of 1 when step==0.
REQ-016 SHALL compute all additions and subtractions at N+1 bits and clamp results to [lo,hi]; out SHALL never leave [lo,hi] and never wrap modulo 2^N.
REQ-017 SHALL set cfg_err=1 when active lo>=hi; while cfg_err=1, out SHALL hold at active lo, wrap=0, dir=0, and ena has no effect.
REQ-018 SHALL, in SAW_UP with ena=1: if out==hi then out<=lo and wrap<=1, else out<=min(out+step,hi); dir=0.
REQ-019 SHALL, in SAW_DOWN with ena=1: if out==lo then out<=hi and wrap<=1, else out<=max(out-step,lo); dir=1.
REQ-020 SHALL, in TRIANGLE with state UP (dir=0): next=min(out+step,hi); if next==hi, state<=DOWN.
REQ-021 SHALL, in TRIANGLE with state DOWN (dir=1): next=max(out-step,lo); if next==lo, state<=UP and wrap<=1 in the same cycle out becomes lo.
REQ-022 SHALL produce TRIANGLE period 2*ceil((hi-lo)/step) samples, so the peak and trough are each held one sample and never repeated.
REQ-023 SHALL, in SQUARE: advance the internal phase counter as in SAW_UP; on each phase wrap, toggle dir and pulse wrap; out SHALL be hi when dir=1 and lo when dir=0.
REQ-024 SHALL set wrap=0 in every cycle not named in REQ-018..REQ-023, including ena=0 cycles.
REQ-025 SHALL hold out, dir, state and the phase counter when ena=0, with no drift.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, set out=0, dir=0, wrap=0, state=UP, phase=0.
REQ-027 SHALL, while rst=1, set active config to mode=TRIANGLE, lo=0, hi=2^N-1, step=1, which gives cfg_err=0.
REQ-028 SHALL abandon any mid-waveform state on reset, and SHALL ignore ena and cfg_load until rst is deasserted.
REQ-029 SHALL reproduce the full-range 0..2^N-1..0 triangle with no cfg_load after reset.

Verification
REQ-030 SHALL cover: reset, then ena=1 with N=8 defaults -> out 0,1,...,255,254,...,0,1; wrap high only when out returns to 0; period 510.
REQ-031 SHALL cover: cfg_load SAW_UP lo=10 hi=20 step=4 -> out 10,14,18,20,10,14; wrap high with each 10 after the first.
REQ-032 SHALL cover: cfg_load TRIANGLE lo=0 hi=7 step=3 -> out 0,3,6,7,4,1,0,3; dir 0,0,0,1,1,1,0,0; wrap with the second 0.
REQ-033 SHALL cover: SQUARE lo=2 hi=200 step=0 with toggled ena and a mid-run rst pulse -> out holds while ena=0; the phase counter treats step as 1; rst forces out=0 immediately, not at the next edge.
REQ-034 SHALL cover: cfg_load with lo=50 hi=50 -> cfg_err=1 and out=50 held; then cfg_load SAW_DOWN lo=0 hi=5 step=2 -> cfg_err=0, out 5,3,1,0,5 with wrap at the second 5.
REQ-035 SHALL cover: cfg_load and ena both high mid-triangle -> restart values appear next cycle with no extra advance and wrap=0.
